// File: rtl/alu_dispatch.sv
// RV32I ALU decode/issue stage: decodes OP, OP-IMM, LUI and AUIPC into ALU
// operands and issues them through a 2-entry skid buffer (R0 output, R1 skid).
module alu_dispatch #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] aluin1,
  output logic [XLEN-1:0] aluin2,
  output logic [2:0]      funct3,
  output logic            alt,
  output logic [4:0]      rd,
  output logic            illegal
);

  typedef struct packed {
    logic [XLEN-1:0] a1;
    logic [XLEN-1:0] a2;
    logic [2:0]      f3;
    logic            alt;
    logic [4:0]      rd;
    logic            ill;
  } ent_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic            w_f7_zero;
  logic            w_f7_alt;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt;
  logic            w_ill;
  ent_t            w_ent;

  assign w_opc     = instr[6:0];
  assign w_f3      = instr[14:12];
  assign w_f7      = instr[31:25];
  assign w_f7_zero = (w_f7 == 7'b0000000);
  assign w_f7_alt  = (w_f7 == 7'b0100000);
  assign w_imm_i   = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign w_imm_u   = {instr[31:12], 12'b0};
  assign w_shamt   = {{(XLEN-5){1'b0}}, instr[24:20]};

  always_comb begin
    w_ent    = '0;
    w_ill    = 1'b0;
    w_ent.rd = instr[11:7];
    unique case (1'b1)
      (w_opc == OPC_OP): begin
        w_ent.a1  = rs1_data;
        w_ent.a2  = rs2_data;
        w_ent.f3  = w_f3;
        w_ent.alt = instr[30];
        w_ill = !(w_f7_zero ||
                  (w_f7_alt && (w_f3 == 3'b000 ||
                                w_f3 == 3'b101)));
      end
      (w_opc == OPC_OPIMM): begin
        w_ent.a1 = rs1_data;
        w_ent.a2 = w_imm_i;
        w_ent.f3 = w_f3;
        if (w_f3 == 3'b001) begin
          w_ent.a2 = w_shamt;
          w_ill    = !w_f7_zero;
        end else if (w_f3 == 3'b101) begin
          w_ent.a2  = w_shamt;
          w_ent.alt = instr[30];
          w_ill     = !(w_f7_zero || w_f7_alt);
        end
      end
      (w_opc == OPC_LUI): begin
        w_ent.a2 = w_imm_u;
      end
      (w_opc == OPC_AUIPC): begin
        w_ent.a1 = pc;
        w_ent.a2 = w_imm_u;
      end
      default: w_ill = 1'b1;
    endcase
    // Illegal entries still issue, but carry no operand data.
    if (w_ill) begin
      w_ent.a1  = '0;
      w_ent.a2  = '0;
      w_ent.f3  = 3'b000;
      w_ent.alt = 1'b0;
    end
    w_ent.ill = w_ill;
  end

  ent_t r_e0, r_e1;
  logic r_v0, r_v1, r_rdy;
  ent_t w_e0_n, w_e1_n;
  logic w_v0_n, w_v1_n;
  logic w_acc, w_drain;

  assign w_acc   = in_valid && r_rdy && !flush;
  assign w_drain = r_v0 && out_ready;

  always_comb begin
    w_e0_n = r_e0;
    w_e1_n = r_e1;
    w_v0_n = r_v0;
    w_v1_n = r_v1;
    if (flush) begin
      w_v0_n = 1'b0;
      w_v1_n = 1'b0;
    end else if (w_drain) begin
      if (r_v1) begin
        w_e0_n = r_e1;
        w_v1_n = 1'b0;
      end else if (w_acc) begin
        w_e0_n = w_ent;
      end else begin
        w_v0_n = 1'b0;
      end
    end else if (!r_v0) begin
      if (w_acc) begin
        w_e0_n = w_ent;
        w_v0_n = 1'b1;
      end
    end else if (w_acc) begin
      w_e1_n = w_ent;
      w_v1_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_v0  <= 1'b0;
      r_v1  <= 1'b0;
      r_rdy <= 1'b1;
    end else begin
      r_e0  <= w_e0_n;
      r_e1  <= w_e1_n;
      r_v0  <= w_v0_n;
      r_v1  <= w_v1_n;
      r_rdy <= !w_v1_n;
    end
  end

  assign in_ready  = r_rdy;
  assign out_valid = r_v0;
  assign aluin1    = r_e0.a1;
  assign aluin2    = r_e0.a2;
  assign funct3    = r_e0.f3;
  assign alt       = r_e0.alt;
  assign rd        = r_e0.rd;
  assign illegal   = r_e0.ill;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed-vector bench for alu_dispatch: decode table plus
// back-pressure, flush and async-reset sequences.
module tb_alu_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] aluin1;
  logic [31:0] aluin2;
  logic [2:0]  funct3;
  logic        alt;
  logic [4:0]  rd;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_dispatch #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluin1(aluin1), .aluin2(aluin2),
    .funct3(funct3), .alt(alt), .rd(rd),
    .illegal(illegal)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input vec_t v);
    chk({v.name, ".valid"},   32'(out_valid), 32'd1);
    chk({v.name, ".aluin1"},  aluin1,         v.a1);
    chk({v.name, ".aluin2"},  aluin2,         v.a2);
    chk({v.name, ".funct3"},  32'(funct3),    32'(v.f3));
    chk({v.name, ".alt"},     32'(alt),       32'(v.alt));
    chk({v.name, ".rd"},      32'(rd),        32'(v.rd));
    chk({v.name, ".illegal"}, 32'(illegal),   32'(v.ill));
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    instr    = v.instr;
    pc       = v.pc;
    rs1_data = v.rs1;
    rs2_data = v.rs2;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    instr    = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"addi",    32'h00500093, 0, 0, 0,
                 0, 5, 3'd0, 0, 5'd1, 0};
    vecs[1]  = '{"sub",     32'h402081B3, 0, 32'h10, 32'h3,
                 32'h10, 32'h3, 3'd0, 1, 5'd3, 0};
    vecs[2]  = '{"lui",     32'h123452B7, 0, 32'hDEAD, 0,
                 0, 32'h12345000, 3'd0, 0, 5'd5, 0};
    vecs[3]  = '{"addi_m1", 32'hFFF00093, 0, 7, 0,
                 7, 32'hFFFFFFFF, 3'd0, 0, 5'd1, 0};
    vecs[4]  = '{"auipc",   32'h00001117, 32'h1000, 32'h99, 0,
                 32'h1000, 32'h1000, 3'd0, 0, 5'd2, 0};
    vecs[5]  = '{"srai",    32'h4030D213, 0, 32'h80000000, 0,
                 32'h80000000, 3, 3'd5, 1, 5'd4, 0};
    vecs[6]  = '{"zero",    32'h00000000, 0, 32'h55, 32'h66,
                 0, 0, 3'd0, 0, 5'd0, 1};
    vecs[7]  = '{"slli_bad", 32'h40109093, 0, 32'h55, 0,
                 0, 0, 3'd0, 0, 5'd1, 1};
    vecs[8]  = '{"sll_alt", 32'h402091B3, 0, 32'h1, 32'h2,
                 0, 0, 3'd0, 0, 5'd3, 1};
    vecs[9]  = '{"sra",     32'h4020D1B3, 0, 32'hF0, 32'h4,
                 32'hF0, 32'h4, 3'd5, 1, 5'd3, 0};
    vecs[10] = '{"ori_min", 32'h8000E093, 0, 32'h1234, 0,
                 32'h1234, 32'hFFFFF800, 3'd6, 0, 5'd1, 0};
    vecs[11] = '{"xori",    32'h4000C093, 0, 32'h77, 0,
                 32'h77, 32'h400, 3'd4, 0, 5'd1, 0};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; instr = 0; pc = 0; rs1_data = 0; rs2_data = 0;
    #12;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.in_ready",  32'(in_ready),  1);
    chk("rst.aluin1",    aluin1,         0);
    chk("rst.aluin2",    aluin2,         0);
    chk("rst.funct3",    32'(funct3),    0);
    chk("rst.alt",       32'(alt),       0);
    chk("rst.rd",        32'(rd),        0);
    chk("rst.illegal",   32'(illegal),   0);
    rst_n = 1'b1;
    tick();

    // Streaming table: one per cycle, zero bubbles
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      tick();
      chk_out(vecs[i]);
      chk({vecs[i].name, ".in_ready"}, 32'(in_ready), 1);
    end
    idle();
    tick();
    chk("drain.out_valid", 32'(out_valid), 0);

    // Back-pressure: A into R0, B into R1
    out_ready = 1'b0;
    drive(vecs[0]);
    tick();
    chk_out(vecs[0]);
    chk("bp.in_ready_a", 32'(in_ready), 1);
    drive(vecs[1]);
    tick();
    chk("bp.in_ready_b", 32'(in_ready), 0);
    chk_out(vecs[0]);
    drive(vecs[2]);
    tick();
    chk("bp.hold_rdy", 32'(in_ready), 0);
    chk_out(vecs[0]);
    idle();
    out_ready = 1'b1;
    tick();
    chk_out(vecs[1]);
    chk("bp.in_ready_ret", 32'(in_ready), 1);
    tick();
    chk("bp.empty", 32'(out_valid), 0);

    // Flush with A in R0, B in R1, C presented
    out_ready = 1'b0;
    drive(vecs[0]);
    tick();
    drive(vecs[1]);
    tick();
    drive(vecs[4]);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("fl.out_valid", 32'(out_valid), 0);
    chk("fl.in_ready",  32'(in_ready),  1);
    out_ready = 1'b1;
    tick();
    chk("fl.c_gone", 32'(out_valid), 0);

    // Flush with in_ready=1: input still discarded
    out_ready = 1'b0;
    drive(vecs[0]);
    tick();
    drive(vecs[4]);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("fl2.out_valid", 32'(out_valid), 0);
    chk("fl2.in_ready",  32'(in_ready),  1);
    tick();
    chk("fl2.c_gone", 32'(out_valid), 0);

    // Accept after flush works normally
    out_ready = 1'b1;
    drive(vecs[9]);
    tick();
    idle();
    chk_out(vecs[9]);

    // Async reset with both entries full
    out_ready = 1'b0;
    drive(vecs[1]);
    tick();
    drive(vecs[5]);
    tick();
    idle();
    chk("ar.full", 32'(in_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.out_valid", 32'(out_valid), 0);
    chk("ar.in_ready",  32'(in_ready),  1);
    chk("ar.aluin1",    aluin1,         0);
    chk("ar.alt",       32'(alt),       0);
    chk("ar.rd",        32'(rd),        0);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("ar.stays_empty", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
